da_stream_driver: RTL and testbench
===================================

DA_STREAM_DRIVER -- requirements
Module: da_stream_driver

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 16, width of LUT words, samples and results.
- LUT_DEPTH, 16, number of precomputed LUT words loaded before operation.
- ADDR_W, 4, LUT write address width; LUT_DEPTH <= 2**ADDR_W.
- TIMEOUT, 32, maximum cycles to wait for core_valid_out.

REQ-002 SHALL have ports, one per line:
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  LUT word offered.
- cfg_data  in  DATA_W  precomputed LUT word.
- cfg_ready  out  1  LUT word accepted when high with cfg_valid.
- s_valid  in  1  input sample offered.
- s_data  in  DATA_W  input sample.
- s_ready  out  1  sample accepted when high with s_valid.
- core_cload  out  1  LUT load mode to DA core.
- core_valid_in  out  1  LUT write strobe to DA core.
- core_wr_addr  out  ADDR_W  LUT write address.
- core_wr_data  out  DATA_W  LUT write data.
- core_start  out  1  one-cycle start pulse to DA core.
- core_x  out  DATA_W  sample held for the core.
- core_valid_out  in  1  core result valid.
- core_y  in  DATA_W  core result.
- m_valid  out  1  result available.
- m_data  out  DATA_W  filtered result.
- m_ready  in  1  result consumed when high with m_valid.
- busy  out  1  high in states other than IDLE and READY.
- err_timeout  out  1  sticky core timeout flag.

Function
REQ-003 SHALL implement the FSM IDLE, LOAD, READY, ISSUE, WAIT, HOLD and ERR, with all outputs registered.
REQ-004 In IDLE and LOAD, cfg_ready SHALL be 1. Each cfg handshake SHALL, on the next cycle, drive core_cload=1, core_valid_in=1, core_wr_addr=word count and core_wr_data=cfg_data for exactly one cycle.
REQ-005 A handshake in IDLE SHALL move to LOAD. Once LUT_DEPTH words are accepted, cfg_ready SHALL drop in the same cycle as the last write strobe, and the state SHALL move to READY.
REQ-006 In READY, cfg_ready SHALL be 0 and cfg_valid SHALL be ignored. The LUT SHALL be reloadable only through reset.
REQ-007 s_ready SHALL be 1 only in READY. A handshake SHALL latch s_data into core_x and move to ISSUE.
REQ-008 ISSUE SHALL assert core_start for exactly one cycle, then move to WAIT with the wait counter cleared. core_x SHALL stay stable until the next sample is accepted.
REQ-009 In WAIT, core_valid_out=1 SHALL capture core_y into m_data, set m_valid=1 and move to HOLD. Result latency from the core_start cycle SHALL be the core's latency plus 1 cycle.
REQ-010 In HOLD, m_valid SHALL stay 1 and m_data SHALL stay stable until m_ready=1. On that edge the block SHALL clear m_valid and return to READY, with s_ready=1 in the following cycle.
REQ-011 Only one sample SHALL be outstanding. core_valid_out outside WAIT SHALL be ignored.
REQ-012 If WAIT lasts TIMEOUT cycles without core_valid_out, the block SHALL set err_timeout=1 and enter ERR. In ERR all handshake readies and core strobes SHALL be 0 until reset.
REQ-013 The wait counter SHALL saturate and SHALL NOT wrap. core_valid_out arriving in the same cycle the count reaches TIMEOUT SHALL win, with the result captured and no error raised.
REQ-014 Samples and results SHALL pass through unmodified; no arithmetic on data is permitted.

Reset
REQ-015 When resetn=0 at a rising edge, the block SHALL enter IDLE and clear every output to 0, including m_data, core_x, core_wr_addr, core_wr_data and err_timeout.
REQ-016 Reset mid-LOAD or mid-WAIT SHALL abandon the operation. The word count SHALL restart at 0 and any pending result SHALL be discarded.
REQ-017 In the reset cycle and the cycle after release, no core strobes SHALL be issued.

Verification
REQ-018 Load 16 words 0x0001..0x0010 back-to-back -> addresses 0..15 strobed with matching data; cfg_ready low after the 16th word; state READY.
REQ-019 Sample 0x1234 with the core returning 0xABCD 10 cycles after core_start, and m_ready held high -> one core_start pulse, m_data=0xABCD, one m_valid cycle, s_ready high on the next cycle.
REQ-020 Hold m_ready=0 for 5 cycles after a result -> m_valid and m_data stable throughout; s_ready stays 0; completes on the first m_ready=1.
REQ-021 No core_valid_out after core_start -> err_timeout=1 exactly TIMEOUT=32 cycles into WAIT; s_ready and cfg_ready stay 0 until reset.
REQ-022 Reset after 7 LUT words, then load 16 words -> addresses restart at 0; the driver reaches READY after the 16th word.
REQ-023 Pulse core_valid_out while in READY -> no m_valid and no state change.

Source files
------------

// File: rtl/da_stream_driver.sv
// Stream front-end for a distributed-arithmetic filter core: loads the core LUT once,
// then feeds one sample at a time and returns the core result over a valid/ready port.
module da_stream_driver #(
  parameter int DATA_W    = 16,
  parameter int LUT_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              core_cload,
  output logic              core_valid_in,
  output logic [ADDR_W-1:0] core_wr_addr,
  output logic [DATA_W-1:0] core_wr_data,
  output logic              core_start,
  output logic [DATA_W-1:0] core_x,
  input  logic              core_valid_out,
  input  logic [DATA_W-1:0] core_y,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LUT_DEPTH - 1);
  localparam logic [CNT_W-1:0]  TMO       = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  TMO_M1    = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, READY, ISSUE, WAIT, HOLD, ERR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;

  logic              cfg_ready_q, cfg_ready_d;
  logic              s_ready_q, s_ready_d;
  logic              cload_q, cload_d;
  logic              wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic cfg_hs, s_hs, res_hs;

  // Handshakes use the registered readies, so they only fire in the states that drive them.
  assign cfg_hs = cfg_valid & cfg_ready_q;
  assign s_hs   = s_valid & s_ready_q;
  assign res_hs = (state_q == WAIT) & core_valid_out;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      cfg_ready_q <= 1'b0;
      s_ready_q   <= 1'b0;
      cload_q     <= 1'b0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      x_q         <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      cfg_ready_q <= cfg_ready_d;
      s_ready_q   <= s_ready_d;
      cload_q     <= cload_d;
      wr_vld_q    <= wr_vld_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      x_q         <= x_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE, LOAD: begin
        if (cfg_hs) begin
          wcnt_d  = wcnt_q + 1'b1;
          state_d = (wcnt_q == LAST_ADDR) ? READY : LOAD;
        end
      end
      READY: if (s_hs) state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: begin
        // A result arriving on the final allowed cycle takes priority over the timeout.
        if (core_valid_out) begin
          state_d = HOLD;
        end else begin
          if (tcnt_q != TMO) tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q >= TMO_M1) state_d = ERR;
        end
      end
      HOLD:    if (m_ready) state_d = READY;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_d = (state_d == IDLE) || (state_d == LOAD);
    s_ready_d   = (state_d == READY);
    start_d     = (state_d == ISSUE);
    cload_d     = cfg_hs;
    wr_vld_d    = cfg_hs;
    wr_addr_d   = cfg_hs ? wcnt_q : '0;
    wr_data_d   = cfg_hs ? cfg_data : '0;
    x_d         = s_hs ? s_data : x_q;
    m_valid_d   = (state_d == HOLD);
    m_data_d    = res_hs ? core_y : m_data_q;
    busy_d      = !((state_d == IDLE) || (state_d == READY));
    err_d       = err_q | (state_d == ERR);
  end

  assign cfg_ready     = cfg_ready_q;
  assign s_ready       = s_ready_q;
  assign core_cload    = cload_q;
  assign core_valid_in = wr_vld_q;
  assign core_wr_addr  = wr_addr_q;
  assign core_wr_data  = wr_data_q;
  assign core_start    = start_q;
  assign core_x        = x_q;
  assign m_valid       = m_valid_q;
  assign m_data        = m_data_q;
  assign busy          = busy_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_da_stream_driver.sv
// Directed bench for da_stream_driver: LUT writes and results are checked against
// scoreboard queues filled as stimulus is driven; the DA core is played by the bench.
module tb_da_stream_driver;
  localparam int DW = 16, LD = 16, AW = 4, TO = 32;

  logic          clk = 1'b0, resetn = 1'b0;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [DW-1:0] cfg_data = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          core_cload, core_valid_in, core_start;
  logic [AW-1:0] core_wr_addr;
  logic [DW-1:0] core_wr_data, core_x;
  logic          core_valid_out = 1'b0;
  logic [DW-1:0] core_y = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          busy, err_timeout;

  always #5 clk = ~clk;

  da_stream_driver #(.DATA_W(DW), .LUT_DEPTH(LD), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .core_cload(core_cload), .core_valid_in(core_valid_in),
    .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_start(core_start), .core_x(core_x),
    .core_valid_out(core_valid_out), .core_y(core_y),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} lut_t;
  lut_t          lut_q[$];
  logic [DW-1:0] res_q[$];
  int            errors = 0, checks = 0, starts = 0;
  logic          mv_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and retire scoreboard entries.
  task automatic tick();
    lut_t e;
    @(posedge clk); #1;
    if (core_start) starts++;
    if (core_valid_in) begin
      if (lut_q.size() == 0) chk("lut_unexpected_strobe", {31'b0, core_valid_in}, 32'd0);
      else begin
        e = lut_q.pop_front();
        chk("lut_addr", {28'b0, core_wr_addr}, {28'b0, e.addr});
        chk("lut_data", {16'b0, core_wr_data}, {16'b0, e.data});
        chk("lut_cload", {31'b0, core_cload}, 32'd1);
      end
    end
    if (m_valid && !mv_prev) begin
      if (res_q.size() == 0) chk("res_unexpected", {31'b0, m_valid}, 32'd0);
      else chk("res_data", {16'b0, m_data}, {16'b0, res_q.pop_front()});
    end
    mv_prev = m_valid;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0; cfg_valid = 1'b0; s_valid = 1'b0; core_valid_out = 1'b0;
    repeat (n) tick();
    lut_q.delete(); res_q.delete();
    resetn = 1'b1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ctl"}, {24'b0, cfg_ready, s_ready, core_cload, core_valid_in, core_start,
                        m_valid, busy, err_timeout}, 32'd0);
    chk({tag, "_dat"}, {m_data, core_x}, 32'd0);
    chk({tag, "_wr"},  {12'b0, core_wr_addr, core_wr_data}, 32'd0);
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    int acc = 0, guard = 0;
    while (acc < n && guard < 200) begin
      cfg_valid = 1'b1;
      cfg_data  = base + DW'(acc);
      if (cfg_ready) begin
        lut_q.push_back({AW'(acc), cfg_data});
        acc++;
      end
      tick();
      guard++;
    end
    cfg_valid = 1'b0;
    chk("load_count", acc, n);
    chk("load_drained", lut_q.size(), 0);
  endtask

  // Leaves the bench in the ISSUE cycle (core_start visible).
  task automatic send_sample(input logic [DW-1:0] d);
    int guard = 0;
    while (!s_ready && guard < 50) begin tick(); guard++; end
    chk("s_ready_wait", {31'b0, s_ready}, 32'd1);
    s_valid = 1'b1; s_data = d;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    int s0;
    do_reset(3);
    chk_cleared("reset");
    tick();
    chk("post_release_strobes", {30'b0, core_valid_in, core_start}, 32'd0);
    chk("post_release_idle", {30'b0, cfg_ready, busy}, 32'h2);

    // Full LUT load, back-to-back.
    load(16, 16'h0001);
    chk("ready_after_load", {29'b0, cfg_ready, s_ready, busy}, 32'h2);
    tick();
    chk("cfg_ready_low", {31'b0, cfg_ready}, 32'd0);

    // cfg writes ignored once loaded.
    cfg_valid = 1'b1; cfg_data = 16'hDEAD;
    repeat (3) tick();
    cfg_valid = 1'b0;
    chk("ready_ignores_cfg", {30'b0, cfg_ready, core_valid_in}, 32'd0);

    // Stray core result in READY.
    core_valid_out = 1'b1; core_y = 16'h5555;
    tick();
    core_valid_out = 1'b0;
    tick();
    chk("stray_result", {14'b0, m_valid, s_ready, m_data}, 32'h0001_0000);

    // Latency-10 core, consumer always ready.
    m_ready = 1'b1;
    s0 = starts;
    send_sample(16'h1234);
    chk("issue_state", {29'b0, core_start, s_ready, busy}, 32'h5);
    chk("core_x", {16'b0, core_x}, 32'h1234);
    repeat (10) tick();
    chk("no_result_early", {31'b0, m_valid}, 32'd0);
    core_valid_out = 1'b1; core_y = 16'hABCD; res_q.push_back(16'hABCD);
    tick();
    core_valid_out = 1'b0;
    chk("result_valid", {15'b0, m_valid, m_data}, 32'h1_ABCD);
    tick();
    chk("after_result", {30'b0, m_valid, s_ready}, 32'h1);
    chk("one_start", starts - s0, 1);
    chk("core_x_stable", {16'b0, core_x}, 32'h1234);

    // Backpressure on the result port; stray core pulses in HOLD ignored.
    m_ready = 1'b0;
    send_sample(16'h00F0);
    repeat (2) tick();
    core_valid_out = 1'b1; core_y = 16'h0BEE; res_q.push_back(16'h0BEE);
    tick();
    for (int i = 0; i < 5; i++) begin
      core_valid_out = 1'b1; core_y = 16'h7777;
      tick();
      chk("hold", {14'b0, m_valid, s_ready, m_data}, 32'h2_0BEE);
    end
    core_valid_out = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("hold_release", {14'b0, m_valid, s_ready, core_x}, 32'h1_00F0);

    // Result on the last allowed WAIT cycle wins over the timeout.
    send_sample(16'h0042);
    repeat (32) tick();
    chk("edge_wait", {30'b0, err_timeout, busy}, 32'h1);
    core_valid_out = 1'b1; core_y = 16'h0C0C; res_q.push_back(16'h0C0C);
    tick();
    core_valid_out = 1'b0;
    chk("edge_result", {14'b0, m_valid, err_timeout, m_data}, 32'h2_0C0C);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("edge_back_ready", {31'b0, s_ready}, 32'd1);

    // Silent core -> timeout.
    send_sample(16'h0099);
    repeat (32) tick();
    chk("tmo_not_yet", {31'b0, err_timeout}, 32'd0);
    tick();
    chk("tmo_set", {30'b0, err_timeout, busy}, 32'h3);
    cfg_valid = 1'b1; s_valid = 1'b1; core_valid_out = 1'b1; core_y = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("err_locked", {27'b0, cfg_ready, s_ready, core_start, m_valid, err_timeout}, 32'h1);
    end
    cfg_valid = 1'b0; s_valid = 1'b0; core_valid_out = 1'b0;

    // Reset mid-load restarts the word count.
    do_reset(2);
    chk_cleared("reset2");
    load(7, 16'h0100);
    do_reset(2);
    chk_cleared("reset3");
    load(16, 16'h0200);
    chk("reload_ready", {30'b0, cfg_ready, s_ready}, 32'h1);

    // Reset mid-WAIT discards the pending result.
    send_sample(16'h0555);
    repeat (3) tick();
    resetn = 1'b0; core_valid_out = 1'b1; core_y = 16'hFFFF;
    tick();
    core_valid_out = 1'b0; resetn = 1'b1;
    chk_cleared("wait_reset");
    tick();
    chk("wait_reset_after", {29'b0, core_valid_in, core_start, m_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
